// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared widths, source encodings and grant helper for mux2x1_arbiter
package mux_arb_pkg;

  localparam int WIDTH_DEF = 32;

  // Source encodings double as the mux select value.
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam logic LAST_GRANT_RST = SRC_B;

  function automatic logic rr_pick(input logic valid_a, input logic valid_b, input logic last_grant);
    logic pick;
    pick = last_grant;
    case ({valid_b, valid_a})
      2'b01:   pick = SRC_A;
      2'b10:   pick = SRC_B;
      2'b11:   pick = ~last_grant;
      default: pick = last_grant;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/mux2x1.sv
// rtl/mux2x1.sv - WIDTH-bit 2:1 multiplexer, sel=0 picks inA, sel=1 picks inB
module mux2x1
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             sel
);

  assign out = (sel == SRC_B) ? inB : inA;

endmodule

// File: rtl/mux2x1_arbiter.sv
// rtl/mux2x1_arbiter.sv - round-robin arbiter over a shared 2:1 mux with a registered valid/ready output stage
// Burst lock input is present only when MUX2X1_ARB_LOCK_EN is defined.
module mux2x1_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] inA,
  input  logic             validA,
  output logic             readyA,
  input  logic [WIDTH-1:0] inB,
  input  logic             validB,
  output logic             readyB,
`ifdef MUX2X1_ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_src
);

  logic             r_last_grant;
  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;
  logic             r_out_src;

  logic             w_sel;
  logic             w_load_en;
  logic             w_xfer;
  logic             w_next_grant;
  logic [WIDTH-1:0] w_mux_out;

  mux2x1 #(.WIDTH(WIDTH)) u_mux (
    .out (w_mux_out),
    .inA (inA),
    .inB (inB),
    .sel (w_sel)
  );

  assign w_sel     = rr_pick(validA, validB, r_last_grant);
  assign w_load_en = !r_out_valid || out_ready;

  assign readyA = !Reset && w_load_en && validA && (w_sel == SRC_A);
  assign readyB = !Reset && w_load_en && validB && (w_sel == SRC_B);
  assign w_xfer = readyA || readyB;

`ifdef MUX2X1_ARB_LOCK_EN
  // Locked transfer points last_grant away from the winner so it wins the next tie too.
  assign w_next_grant = lock ? ~w_sel : w_sel;
`else
  assign w_next_grant = w_sel;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_out_src    <= SRC_A;
      r_last_grant <= LAST_GRANT_RST;
    end else if (w_xfer) begin
      r_out        <= w_mux_out;
      r_out_valid  <= 1'b1;
      r_out_src    <= w_sel;
      r_last_grant <= w_next_grant;
    end else if (r_out_valid && out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign out_src   = r_out_src;

endmodule
